// File: rtl/mux_bbm_sequencer_if.sv
// Configuration handshake and switch-drive bundle for the break-before-make mux sequencer.
interface mux_bbm_sequencer_if #(
  parameter int unsigned W = 8
) ();
  logic         cfg_valid;
  logic [W-1:0] cfg_p;
  logic [W-1:0] cfg_n;
  logic         cfg_ready;
  logic         force_off;
  logic [W-1:0] sw_p;
  logic [W-1:0] sw_n;
  logic         busy;
  logic         done;
  logic         err;

  // Requester side: offers configurations and may force all switches open.
  modport master (
    output cfg_valid, cfg_p, cfg_n, force_off,
    input  cfg_ready, sw_p, sw_n, busy, done, err
  );

  // Sequencer side.
  modport slave (
    input  cfg_valid, cfg_p, cfg_n, force_off,
    output cfg_ready, sw_p, sw_n, busy, done, err
  );
endinterface

// File: rtl/mux_bbm_sequencer.sv
// Break-before-make sequencer for a differential analog mux: every change of switch
// configuration opens all switches for BREAK_CYCLES, applies the new selection, then
// holds busy for SETTLE_CYCLES before reporting done.
module mux_bbm_sequencer #(
  parameter int unsigned W             = 8,
  parameter int unsigned BREAK_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input logic                clk,
  input logic                rst,  // active-low, asynchronous
  mux_bbm_sequencer_if.slave bus
);

  localparam int unsigned MaxCyc = (BREAK_CYCLES > SETTLE_CYCLES) ? BREAK_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  // Counters load N-1 and the phase ends on the edge that observes zero, giving N cycles.
  localparam logic [CntW-1:0] BreakLoad  = CntW'(BREAK_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBreak, StSettle} state_e;

  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic [W-1:0]    r_lat_p, w_lat_p_next;
  logic [W-1:0]    r_lat_n, w_lat_n_next;
  logic [W-1:0]    r_sw_p, w_sw_p_next;
  logic [W-1:0]    r_sw_n, w_sw_n_next;
  logic            r_done, w_done_next;
  logic            r_err, w_err_next;

  logic w_conflict;
  logic w_same;

  assign w_conflict = |(bus.cfg_p & bus.cfg_n);
  assign w_same     = (bus.cfg_p == r_sw_p) && (bus.cfg_n == r_sw_n);

  // Next-state logic; force_off overrides any sequence in progress and drops a same-edge cfg.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_lat_p_next = r_lat_p;
    w_lat_n_next = r_lat_n;
    w_sw_p_next  = r_sw_p;
    w_sw_n_next  = r_sw_n;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    if (bus.force_off) begin
      w_state_next = StIdle;
      w_cnt_next   = '0;
      w_lat_p_next = '0;
      w_lat_n_next = '0;
      w_sw_p_next  = '0;
      w_sw_n_next  = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.cfg_valid) begin
            if (w_conflict) begin
              w_err_next = 1'b1;
            end else if (w_same) begin
              w_done_next = 1'b1;
            end else begin
              w_state_next = StBreak;
              w_cnt_next   = BreakLoad;
              w_lat_p_next = bus.cfg_p;
              w_lat_n_next = bus.cfg_n;
              w_sw_p_next  = '0;
              w_sw_n_next  = '0;
            end
          end
        end
        StBreak: begin
          if (r_cnt == '0) begin
            w_state_next = StSettle;
            w_cnt_next   = SettleLoad;
            w_sw_p_next  = r_lat_p;
            w_sw_n_next  = r_lat_n;
          end else begin
            w_cnt_next = r_cnt - CntW'(1);
          end
        end
        StSettle: begin
          if (r_cnt == '0) begin
            w_state_next = StIdle;
            w_done_next  = 1'b1;
          end else begin
            w_cnt_next = r_cnt - CntW'(1);
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_lat_p <= '0;
      r_lat_n <= '0;
      r_sw_p  <= '0;
      r_sw_n  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_lat_p <= w_lat_p_next;
      r_lat_n <= w_lat_n_next;
      r_sw_p  <= w_sw_p_next;
      r_sw_n  <= w_sw_n_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
    end
  end

  assign bus.cfg_ready = (r_state == StIdle);
  assign bus.busy      = (r_state != StIdle);
  assign bus.sw_p      = r_sw_p;
  assign bus.sw_n      = r_sw_n;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_mux_bbm_sequencer.sv
// Self-checking bench for mux_bbm_sequencer: directed scenarios plus randomized traffic,
// all checked against a timestamp-based model of the sequencing rules.
module tb_mux_bbm_sequencer;

  localparam int W  = 8;
  localparam int B  = 4;
  localparam int S  = 8;
  localparam int OW = 2 * W + 4;

  // Observation vector layout: {sw_p, sw_n, busy, cfg_ready, done, err}
  localparam logic [OW-1:0] IdleZero = OW'(4'b0100);

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mux_bbm_sequencer_if #(.W(W)) bus ();

  mux_bbm_sequencer #(
    .W             (W),
    .BREAK_CYCLES  (B),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: applied configuration plus the edge number at which a change was accepted.
  int           cyc = 0;
  int           m_t0 = 0;
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  bit           m_err = 1'b0;
  logic [W-1:0] m_sw_p = '0;
  logic [W-1:0] m_sw_n = '0;

  function automatic logic [OW-1:0] obs();
    return {bus.sw_p, bus.sw_n, bus.busy, bus.cfg_ready, bus.done, bus.err};
  endfunction

  function automatic logic [OW-1:0] exp_vec();
    logic [W-1:0] p, n;
    if (m_busy && (cyc < m_t0 + B)) begin
      p = '0;
      n = '0;
    end else begin
      p = m_sw_p;
      n = m_sw_n;
    end
    return {p, n, m_busy, ~m_busy, m_done, m_err};
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_sw_p = '0;
    m_sw_n = '0;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] p, input logic [W-1:0] n,
                       input logic f);
    bus.cfg_valid = v;
    bus.cfg_p     = p;
    bus.cfg_n     = n;
    bus.force_off = f;
  endtask

  // Advance one clock edge, settle, and update the model from the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!rst) begin
      model_reset();
    end else if (bus.force_off) begin
      model_reset();
    end else if (m_busy) begin
      if (cyc == m_t0 + B + S) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (bus.cfg_valid) begin
      if ((bus.cfg_p & bus.cfg_n) != '0) begin
        m_err = 1'b1;
      end else if (bus.cfg_p == m_sw_p && bus.cfg_n == m_sw_n) begin
        m_done = 1'b1;
      end else begin
        m_busy = 1'b1;
        m_t0   = cyc;
        m_sw_p = bus.cfg_p;
        m_sw_n = bus.cfg_n;
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, 1'b0);
    #1 rst = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (obs() !== IdleZero) begin
      n_err++;
      $display("FAIL reset_async got=%h want=%h", obs(), IdleZero);
    end
    tick();
    tick();
    n_vec++;
    if (obs() !== IdleZero) begin
      n_err++;
      $display("FAIL reset_held got=%h want=%h", obs(), IdleZero);
    end
    #2 rst = 1'b1;
    tick();
    n_vec++;
    if (obs() !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_release got=%h want=%h", obs(), exp_vec());
    end
  endtask

  task automatic test_first_cfg();
    int busy_n, zero_n, done_at;
    drive(1'b1, 8'h01, 8'h02, 1'b0);
    tick();
    drive(1'b0, 8'hff, 8'hff, 1'b0);
    busy_n  = 0;
    zero_n  = 0;
    done_at = -1;
    for (int j = 0; j <= 14; j++) begin
      if (j > 0) tick();
      n_vec++;
      if (obs() !== exp_vec()) begin
        n_err++;
        $display("FAIL first_cfg j=%0d got=%h want=%h", j, obs(), exp_vec());
      end
      if (bus.busy) busy_n++;
      if (bus.sw_p == '0 && bus.sw_n == '0) zero_n++;
      if (bus.done && done_at < 0) done_at = j;
    end
    n_vec++;
    if (busy_n != B + S) begin
      n_err++;
      $display("FAIL first_cfg_busy_len got=%0d want=%0d", busy_n, B + S);
    end
    n_vec++;
    if (zero_n != B) begin
      n_err++;
      $display("FAIL first_cfg_break_len got=%0d want=%0d", zero_n, B);
    end
    n_vec++;
    if (done_at != B + S) begin
      n_err++;
      $display("FAIL first_cfg_done_at got=%0d want=%0d", done_at, B + S);
    end
    n_vec++;
    if ({bus.sw_p, bus.sw_n} !== 16'h0102) begin
      n_err++;
      $display("FAIL first_cfg_final got=%h want=0102", {bus.sw_p, bus.sw_n});
    end
  endtask

  task automatic test_bbm();
    int zero_n, done_at;
    logic [2*W-1:0] cur;
    drive(1'b1, 8'h04, 8'h08, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    zero_n  = 0;
    done_at = -1;
    for (int j = 0; j <= 13; j++) begin
      if (j > 0) tick();
      cur = {bus.sw_p, bus.sw_n};
      n_vec++;
      if (obs() !== exp_vec()) begin
        n_err++;
        $display("FAIL bbm j=%0d got=%h want=%h", j, obs(), exp_vec());
      end
      n_vec++;
      if (cur !== 16'h0000 && cur !== 16'h0102 && cur !== 16'h0408) begin
        n_err++;
        $display("FAIL bbm_mix j=%0d got=%h want=0000/0408", j, cur);
      end
      if (cur == '0) zero_n++;
      if (bus.done && done_at < 0) done_at = j;
    end
    n_vec++;
    if (zero_n != B) begin
      n_err++;
      $display("FAIL bbm_break_len got=%0d want=%0d", zero_n, B);
    end
    n_vec++;
    if (done_at != B + S) begin
      n_err++;
      $display("FAIL bbm_done_at got=%0d want=%0d", done_at, B + S);
    end
  endtask

  task automatic test_no_change();
    drive(1'b1, 8'h04, 8'h08, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    n_vec++;
    if (obs() !== {8'h04, 8'h08, 4'b0110}) begin
      n_err++;
      $display("FAIL no_change got=%h want=%h", obs(), {8'h04, 8'h08, 4'b0110});
    end
    tick();
    n_vec++;
    if (obs() !== exp_vec()) begin
      n_err++;
      $display("FAIL no_change_after got=%h want=%h", obs(), exp_vec());
    end
  endtask

  task automatic test_conflict();
    drive(1'b1, 8'h10, 8'h10, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    n_vec++;
    if (obs() !== {8'h04, 8'h08, 4'b0101}) begin
      n_err++;
      $display("FAIL conflict got=%h want=%h", obs(), {8'h04, 8'h08, 4'b0101});
    end
    tick();
    n_vec++;
    if (obs() !== {8'h04, 8'h08, 4'b0100}) begin
      n_err++;
      $display("FAIL conflict_after got=%h want=%h", obs(), {8'h04, 8'h08, 4'b0100});
    end
  endtask

  // Abort once in BREAK and once in SETTLE while cfg_valid stays asserted.
  task automatic test_force_off();
    logic [W-1:0] ps [2];
    logic [W-1:0] ns [2];
    int           pre [2];
    ps[0] = 8'h20; ns[0] = 8'h40; pre[0] = 1;
    ps[1] = 8'h02; ns[1] = 8'h01; pre[1] = B + 4;
    for (int t = 0; t < 2; t++) begin
      drive(1'b1, ps[t], ns[t], 1'b0);
      tick();
      for (int j = 0; j < pre[t]; j++) begin
        tick();
        n_vec++;
        if (obs() !== exp_vec()) begin
          n_err++;
          $display("FAIL force_pre t=%0d j=%0d got=%h want=%h", t, j, obs(), exp_vec());
        end
      end
      drive(1'b1, ps[t], ns[t], 1'b1);
      tick();
      n_vec++;
      if (obs() !== IdleZero) begin
        n_err++;
        $display("FAIL force_abort t=%0d got=%h want=%h", t, obs(), IdleZero);
      end
      drive(1'b1, ps[t], ns[t], 1'b0);
      for (int j = 0; j < B + S + 2; j++) begin
        tick();
        n_vec++;
        if (obs() !== exp_vec()) begin
          n_err++;
          $display("FAIL force_resume t=%0d j=%0d got=%h want=%h", t, j, obs(), exp_vec());
        end
      end
      drive(1'b0, '0, '0, 1'b0);
      tick();
    end
  endtask

  task automatic test_async_reset();
    int done_at, busy_n;
    drive(1'b1, 8'h30, 8'h03, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    repeat (B + 5) tick();
    n_vec++;
    if (obs() !== {8'h30, 8'h03, 4'b1000}) begin
      n_err++;
      $display("FAIL arst_pre got=%h want=%h", obs(), {8'h30, 8'h03, 4'b1000});
    end
    #3 rst = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (obs() !== IdleZero) begin
      n_err++;
      $display("FAIL arst_immediate got=%h want=%h", obs(), IdleZero);
    end
    tick();
    tick();
    #2 rst = 1'b1;
    drive(1'b1, 8'h80, 8'h01, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    busy_n  = 0;
    done_at = -1;
    for (int j = 0; j <= 13; j++) begin
      if (j > 0) tick();
      n_vec++;
      if (obs() !== exp_vec()) begin
        n_err++;
        $display("FAIL arst_seq j=%0d got=%h want=%h", j, obs(), exp_vec());
      end
      if (bus.busy) busy_n++;
      if (bus.done && done_at < 0) done_at = j;
    end
    n_vec++;
    if (busy_n != B + S || done_at != B + S) begin
      n_err++;
      $display("FAIL arst_seq_len got=busy %0d done %0d want=%0d", busy_n, done_at, B + S);
    end
    n_vec++;
    if ({bus.sw_p, bus.sw_n} !== 16'h8001) begin
      n_err++;
      $display("FAIL arst_final got=%h want=8001", {bus.sw_p, bus.sw_n});
    end
  endtask

  task automatic test_random();
    logic [W-1:0]   p, n;
    logic [2*W-1:0] cur, last_nz;
    bit             have_nz;
    bit             v, f;
    int             r, zrun;
    cur     = {bus.sw_p, bus.sw_n};
    last_nz = cur;
    have_nz = (cur != '0);
    zrun    = 0;
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 1) == 1);
      p = W'($urandom);
      n = W'($urandom) & ~p;
      r = $urandom_range(0, 15);
      if (r == 0) begin
        p = p | 8'h01;
        n = n | 8'h01;
      end else if (r == 1) begin
        p = m_sw_p;
        n = m_sw_n;
      end
      f = ($urandom_range(0, 39) == 0);
      drive(v, p, n, f);
      tick();
      n_vec++;
      if (obs() !== exp_vec()) begin
        n_err++;
        $display("FAIL random i=%0d got=%h want=%h", i, obs(), exp_vec());
      end
      n_vec++;
      if ((bus.sw_p & bus.sw_n) !== '0) begin
        n_err++;
        $display("FAIL random_overlap i=%0d got=%h want=00", i, bus.sw_p & bus.sw_n);
      end
      cur = {bus.sw_p, bus.sw_n};
      if (cur != '0) begin
        n_vec++;
        if (have_nz && cur != last_nz && zrun < B) begin
          n_err++;
          $display("FAIL random_break i=%0d got=%0d zero cycles want>=%0d", i, zrun, B);
        end
        last_nz = cur;
        have_nz = 1'b1;
        zrun    = 0;
      end else begin
        zrun++;
      end
    end
    drive(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b0);
    test_reset();
    test_first_cfg();
    test_bbm();
    test_no_change();
    test_conflict();
    test_force_off();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_bbm_sequencer.md
MUX_BBM_SEQUENCER -- requirements
Module: mux_bbm_sequencer

Interface
REQ-001 SHALL have parameter W, default 8: width of each switch-select vector.
REQ-002 SHALL have parameter BREAK_CYCLES, default 4 (legal >=1): cycles with all switches open before a new configuration is applied.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 8 (legal >=1): cycles held busy after a new configuration is applied.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 cfg_valid  input  1  new switch configuration offered.
REQ-007 cfg_p  input  W  requested positive-rail switch select.
REQ-008 cfg_n  input  W  requested negative-rail switch select.
REQ-009 cfg_ready  output  1  sequencer can accept a configuration.
REQ-010 force_off  input  1  synchronous request to open all switches immediately.
REQ-011 sw_p  output  W  registered positive-rail switch drive to the analog mux.
REQ-012 sw_n  output  W  registered negative-rail switch drive to the analog mux.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse: requested configuration is applied and settled.
REQ-015 err  output  1  one-cycle pulse: configuration rejected.

Function
REQ-016 SHALL implement states IDLE, BREAK and SETTLE; cfg_ready SHALL equal (state==IDLE) and SHALL be combinational from state only.
REQ-017 Handshake: a configuration SHALL be accepted on a rising edge where cfg_valid and cfg_ready are both 1; cfg_valid without cfg_ready SHALL be ignored.
REQ-018 Conflict: if an accepted cfg_p & cfg_n is non-zero, sw_p/sw_n SHALL be unchanged, state SHALL stay IDLE, err SHALL pulse on the next cycle, and done SHALL NOT pulse.
REQ-019 No-change: if an accepted, non-conflicting configuration equals the current sw_p/sw_n, state SHALL stay IDLE, outputs SHALL be unchanged, and done SHALL pulse on the next cycle with no break interval.
REQ-020 Change, accept edge k: sw_p and sw_n SHALL become 0 at edge k, the state SHALL become BREAK, and the new configuration SHALL be latched internally.
REQ-021 sw_p/sw_n SHALL remain 0 for exactly BREAK_CYCLES cycles; at edge k+BREAK_CYCLES they SHALL take the latched values and the state SHALL become SETTLE.
REQ-022 At edge k+BREAK_CYCLES+SETTLE_CYCLES the state SHALL return to IDLE and done SHALL be 1 for that single cycle.
REQ-023 Cycle counters SHALL be sized $clog2(max(BREAK_CYCLES,SETTLE_CYCLES)+1) and SHALL load on entry to BREAK and SETTLE; they SHALL never wrap.
REQ-024 Outputs SHALL never have any bit set in both sw_p and sw_n.
REQ-025 Outputs SHALL never change directly from one non-zero configuration to another without at least BREAK_CYCLES cycles at 0.
REQ-026 force_off SHALL take priority over everything: on that edge sw_p, sw_n, counters and the latched configuration SHALL clear, state SHALL become IDLE, and done/err SHALL be 0.
REQ-027 cfg_valid on the same edge as force_off SHALL be dropped.
REQ-028 force_off arriving mid-BREAK or mid-SETTLE SHALL abort the sequence without a done pulse.
REQ-029 cfg_p/cfg_n SHALL be sampled only on the accept edge; later changes while busy SHALL have no effect.

Reset
REQ-030 While rst=0, regardless of clk: sw_p=0, sw_n=0, state=IDLE, busy=0, done=0, err=0, counters and latched configuration=0, cfg_ready=1.
REQ-031 Reset asserted mid-sequence SHALL abort immediately to the reset values; the first cfg accepted after release SHALL run a full BREAK/SETTLE sequence if non-zero.

Verification (defaults W=8, BREAK=4, SETTLE=8)
REQ-032 Reset, then cfg p=0x01 n=0x02: sw=0 for 4 cycles, then sw_p=0x01/sw_n=0x02; done pulses 12 cycles after accept; busy high for exactly 12 cycles.
REQ-033 From p=0x01/n=0x02, cfg p=0x04 n=0x08: sw drops to 0x00/0x00 for 4 cycles before 0x04/0x08; no cycle shows a mix of old and new bits.
REQ-034 Re-send p=0x04 n=0x08 while idle: done the next cycle, busy stays 0, sw unchanged.
REQ-035 cfg p=0x10 n=0x10: err pulses one cycle; sw and state unchanged; no done.
REQ-036 force_off at BREAK cycle 2, and separately at SETTLE cycle 5: sw=0 and IDLE on the next edge, no done; a cfg_valid held throughout busy is accepted only once cfg_ready=1.
REQ-037 Assert rst asynchronously mid-SETTLE between clock edges: outputs clear without waiting for clk; after release, p=0x80 n=0x01 completes a full 12-cycle sequence.
